// File: rtl/strength_bus_pkg.sv
// Shared types and width helpers for the strength-resolved bus arbiter.
package strength_bus_pkg;

    // Arbiter states; TURN is only entered when ARB_TURNAROUND_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    // Supported requester count range.
    localparam int MIN_REQ = 2;
    localparam int MAX_REQ = 16;

    // Width of an index able to name any of n requesters.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter able to hold the value max_hold.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/strength_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first requester
// with req set and not excluded, scanning from ptr upward modulo N.
module rr_pick
    import strength_bus_pkg::*;
#(
    parameter int N = 4,
    localparam int OW = owner_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] ptr,
    input  logic [N-1:0]  exclude,
    output logic          valid,
    output logic [OW-1:0] idx
);

    logic [N-1:0] cand;

    assign cand = req & ~exclude;

    // Scan candidates starting at ptr; the first hit wins.
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && cand[j]) begin
                valid = 1'b1;
                idx   = OW'(j);
            end
        end
    end

endmodule

// File: rtl/strength_bus_arbiter.sv
// strength_bus_arbiter: round-robin owner selection for a shared bus with a
// weak pull fallback. Grant/owner are registered; bus is resolved
// combinationally from the registered grant and the live wdata.
// Optional macro ARB_TURNAROUND_EN inserts one all-zero grant cycle (TURN)
// on every owner change.
module strength_bus_arbiter
    import strength_bus_pkg::*;
#(
    parameter int             N        = 4,
    parameter int             W        = 32,
    parameter int             MAX_HOLD = 8,
    parameter logic [W-1:0]   PULL_VAL = '1,
    localparam int            OW       = owner_width(N),
    localparam int            HW       = hold_width(MAX_HOLD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    wdata,
    output logic [N-1:0]      grant,
    output logic [OW-1:0]     owner,
    output logic [W-1:0]      bus,
    output logic              bus_idle
);

    arb_state_e    state;
    logic [OW-1:0] ptr;
    logic [HW-1:0] hold_cnt;

    logic          owner_req;
    logic          others_req;
    logic          at_max;
    logic          release_now;
    logic [N-1:0]  pick_excl;
    logic          pick_valid;
    logic [OW-1:0] pick_idx;

    // Pointer following a grant to idx, wrapping at N.
    function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] idx);
        return (int'(idx) == N - 1) ? '0 : idx + OW'(1);
    endfunction

    // One-hot grant vector for index idx.
    function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
        return N'(1) << idx;
    endfunction

    assign owner_req   = |(req & grant);
    assign others_req  = |(req & ~grant);
    assign at_max      = (hold_cnt == HW'(MAX_HOLD));
    assign release_now = (state == OWN) && (!owner_req || (at_max && others_req));

    // A releasing owner is never a candidate for its own hand-off.
    assign pick_excl   = (state == OWN) ? grant : '0;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .exclude (pick_excl),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Arbitration FSM with registered grant, owner, pointer and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            owner    <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (pick_valid) begin
                        state    <= OWN;
                        grant    <= onehot(pick_idx);
                        owner    <= pick_idx;
                        ptr      <= next_ptr(pick_idx);
                        hold_cnt <= HW'(1);
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
                        hold_cnt <= '0;
                    end
                end
                OWN: begin
                    if (release_now) begin
`ifdef ARB_TURNAROUND_EN
                        state    <= TURN;
                        grant    <= '0;
                        hold_cnt <= '0;
`else
                        if (pick_valid) begin
                            state    <= OWN;
                            grant    <= onehot(pick_idx);
                            owner    <= pick_idx;
                            ptr      <= next_ptr(pick_idx);
                            hold_cnt <= HW'(1);
                        end else begin
                            state    <= IDLE;
                            grant    <= '0;
                            hold_cnt <= '0;
                        end
`endif
                    end else begin
                        // Uncontested owner at the limit keeps the bus; count restarts.
                        hold_cnt <= at_max ? HW'(1) : hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Resolve the bus: granted slice, otherwise the weak pull value.
    always_comb begin
        bus = PULL_VAL;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) bus = wdata[i*W +: W];
        end
    end

    assign bus_idle = ~|grant;

endmodule

// File: tb/tb_strength_bus_arbiter.sv
// Scoreboard bench for strength_bus_arbiter (N=4, W=32, MAX_HOLD=8).
// Expected grant/owner are predicted from a behavioral model when inputs are
// driven, queued, and compared at the following negative clock edge.
module tb_strength_bus_arbiter;

    localparam int          N        = 4;
    localparam int          W        = 32;
    localparam int          MAX_HOLD = 8;
    localparam logic [31:0] PULL     = 32'hFFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic [W-1:0]   bus;
    logic           bus_idle;

    typedef struct {
        logic [N-1:0] grant;
        int           own;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    int m_state;
    int m_ptr;
    int m_hold;
    int m_own;

    strength_bus_arbiter #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MAX_HOLD),
        .PULL_VAL (PULL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .grant    (grant),
        .owner    (owner),
        .bus      (bus),
        .bus_idle (bus_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_winner(input logic [N-1:0] r, input int start, input int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_state = 1;
        m_own   = w;
        m_ptr   = (w + 1) % N;
        m_hold  = 1;
    endtask

    task automatic model_idle();
        m_state = 0;
        m_own   = -1;
        m_hold  = 0;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        int   w;
        exp_t e;
        if (rst) begin
            model_idle();
            m_ptr = 0;
        end else if (m_state != 1) begin
            w = find_winner(req, m_ptr, -1);
            if (w >= 0) model_grant(w);
            else model_idle();
        end else if (!req[m_own] ||
                     (m_hold == MAX_HOLD && (req & ~(4'b0001 << m_own)) != 4'b0000)) begin
`ifdef ARB_TURNAROUND_EN
            m_state = 2;
            m_own   = -1;
            m_hold  = 0;
`else
            w = find_winner(req, m_ptr, m_own);
            if (w >= 0) model_grant(w);
            else model_idle();
`endif
        end else begin
            m_hold = (m_hold == MAX_HOLD) ? 1 : m_hold + 1;
        end
        e.grant = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
        e.own   = m_own;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t        e;
        logic [31:0] eb;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            eb = (e.own >= 0) ? wdata[e.own*W +: W] : PULL;
            chk("grant", grant, e.grant);
            chk("bus_idle", bus_idle, (e.own < 0));
            chk("bus", bus, eb);
            chk("onehot", $onehot0(grant), 1);
            if (e.own >= 0) chk("owner", owner, e.own);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
        @(negedge clk);
        compare();
        rst   = r;
        req   = q;
        wdata = d;
        model_edge();
    endtask

    function automatic logic [N*W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   q;

        m_ptr = 0;
        model_idle();
        rst   = 1'b1;
        req   = 4'b1111;
        wdata = '0;
        model_edge();

        // Reset held two cycles with every request high.
        step(1'b1, 4'b1111, '0);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_bus", bus, PULL);
        chk("rst_idle", bus_idle, 1'b1);
        step(1'b0, 4'b1111, '0);
        step(1'b0, 4'b1111, '0);
        chk("first_grant", grant, 4'b0001);

        // Single requester held well past MAX_HOLD.
        step(1'b1, 4'b0000, '0);
        d = '0;
        d[2*W +: W] = 32'hA5A5_0000;
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0100, d);
        chk("single_grant", grant, 4'b0100);
        chk("single_bus", bus, 32'hA5A5_0000);

        // Fairness with everyone requesting.
        step(1'b1, 4'b0000, '0);
        for (int i = 0; i < 40; i++) step(1'b0, 4'b1111, rand_data());

        // Owner 1 drops while 3 is waiting.
        step(1'b1, 4'b0000, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1010, rand_data());
        chk("handoff_own1", grant, 4'b0010);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, rand_data());
        chk("handoff_own3", grant, 4'b1000);

        // Reset pulse during ownership of index 2.
        step(1'b1, 4'b0000, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, rand_data());
        chk("mid_own2", grant, 4'b0100);
        step(1'b1, 4'b0110, rand_data());
        step(1'b0, 4'b0110, rand_data());
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_idle", bus_idle, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0110, rand_data());
        chk("mid_after_rst", grant, 4'b0010);

        // Random traffic with sticky requests.
        q = 4'b0000;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
            step(1'b0, q, rand_data());
        end

        @(negedge clk);
        compare();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
